legv8_mc_control: RTL and testbench

Multi-cycle control unit for the LEGv8 datapath. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back. It waits on a shared memory ready handshake and supervises memory accesses with a timeout. It sits between the instruction register's opcode field and the multi-cycle datapath muxes and enables.

---
 rtl/legv8_ctrl_pkg.sv | 46 ++++
 rtl/legv8_op_classify.sv | 38 +++
 rtl/legv8_mc_control.sv | 171 +++++++++++++++++
 tb/tb_legv8_mc_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  legv8_ctrl_pkg : shared encodings for the LEGv8 multi-cycle control unit
//  Revision 1.0
// ============================================================================
package legv8_ctrl_pkg;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_RTYPE   = 3'd1,
      CLS_LDUR    = 3'd2,
      CLS_STUR    = 3'd3,
      CLS_CBZ     = 3'd4,
      CLS_B       = 3'd5,
      CLS_ILLEGAL = 3'd6
   } op_class_t;

   localparam logic [10:0] RTYPE_MASK  = 11'b100_1111_0111;
   localparam logic [10:0] RTYPE_MATCH = 11'b100_0101_0000;
   localparam logic [10:0] LDUR_MASK   = 11'b111_1111_1111;
   localparam logic [10:0] LDUR_MATCH  = 11'b111_1100_0010;
   localparam logic [10:0] STUR_MASK   = 11'b111_1111_1111;
   localparam logic [10:0] STUR_MATCH  = 11'b111_1100_0000;
   localparam logic [10:0] CBZ_MASK    = 11'b111_1111_1000;
   localparam logic [10:0] CBZ_MATCH   = 11'b101_1010_0000;
   localparam logic [10:0] B_MASK      = 11'b111_1110_0000;
   localparam logic [10:0] B_MATCH     = 11'b000_1010_0000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   function automatic logic op_match(input logic [10:0] op,
                                     input logic [10:0] mask,
                                     input logic [10:0] match);
      return (op & mask) == match;
   endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_op_classify.sv
`default_nettype none
// ============================================================================
//  legv8_op_classify : combinational opcode-to-class decoder (upper 11 bits)
//  Optional B decode under LEGV8_B_EN.  Revision 1.0
// ============================================================================
module legv8_op_classify
   import legv8_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 11
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_t           class_o
);

   logic [10:0] w_op;
   assign w_op = opcode_i[OPCODE_W-1 -: 11];

   always_comb begin
      class_o = CLS_ILLEGAL;
      if (op_match(w_op, LDUR_MASK, LDUR_MATCH))
         class_o = CLS_LDUR;
      else if (op_match(w_op, STUR_MASK, STUR_MATCH))
         class_o = CLS_STUR;
      else if (op_match(w_op, RTYPE_MASK, RTYPE_MATCH))
         class_o = CLS_RTYPE;
      else if (op_match(w_op, CBZ_MASK, CBZ_MATCH))
         class_o = CLS_CBZ;
`ifdef LEGV8_B_EN
      else if (op_match(w_op, B_MASK, B_MATCH))
         class_o = CLS_B;
`else
      else
         class_o = CLS_ILLEGAL;
`endif
   end

endmodule
`default_nettype wire

// File: rtl/legv8_mc_control.sv
`default_nettype none
// ============================================================================
//  legv8_mc_control : multi-cycle LEGv8 control FSM (IF/ID/EX/MEM/WB) with
//  memory-wait timeout; unconditional B enabled by LEGV8_B_EN.  Revision 1.0
// ============================================================================
module legv8_mc_control
   import legv8_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 11,
   parameter int TIMEOUT_W   = 4,
   parameter int TIMEOUT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                reg2loc,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                branch,
   output logic [1:0]          alu_op,
   output logic                ior_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                retire,
   output logic                illegal,
   output logic                mem_fault,
   output logic [2:0]          state
);

   localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_MAX);

   logic [2:0]           state_q, state_d;
   op_class_t            cls_q, cls_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   op_class_t            w_class;
   logic                 w_mem_state;
   logic                 w_timeout;

   legv8_op_classify #(.OPCODE_W(OPCODE_W)) u_classify (
      .opcode_i (opcode),
      .class_o  (w_class)
   );

   assign w_mem_state = (state_q == S_IF) || (state_q == S_MEM);
   // A late mem_ready on the final count wins over the fault.
   assign w_timeout   = w_mem_state && (cnt_q == TMAX) && !mem_ready;
   assign state       = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IF;
         cls_q   <= CLS_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = S_IF;
      cls_d   = cls_q;
      cnt_d   = '0;
      if (w_mem_state && !mem_ready && !w_timeout)
         cnt_d = cnt_q + TIMEOUT_W'(1);
      case (state_q)
         S_IF:  state_d = mem_ready ? S_ID : S_IF;
         S_ID: begin
            state_d = S_EX;
            cls_d   = w_class;
         end
         S_EX: begin
            case (cls_q)
               CLS_RTYPE:           state_d = S_WB;
               CLS_LDUR, CLS_STUR:  state_d = S_MEM;
               default:             state_d = S_IF;
            endcase
         end
         S_MEM: begin
            if (mem_ready)
               state_d = (cls_q == CLS_LDUR) ? S_WB : S_IF;
            else if (!w_timeout && (cls_q == CLS_LDUR || cls_q == CLS_STUR))
               state_d = S_MEM;
            else
               state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_op     = ALUOP_ADD;
      ior_d      = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      mem_fault  = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_IF: begin
               mem_read  = !w_timeout;
               mem_fault = w_timeout;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_EX: begin
               case (cls_q)
                  CLS_RTYPE: alu_op = ALUOP_RTYPE;
                  CLS_LDUR:  alu_src = 1'b1;
                  CLS_STUR: begin
                     alu_src = 1'b1;
                     reg2loc = 1'b1;
                  end
                  CLS_CBZ: begin
                     reg2loc  = 1'b1;
                     alu_op   = ALUOP_PASSB;
                     branch   = 1'b1;
                     pc_write = zero;
                     pc_src   = zero;
                     retire   = 1'b1;
                  end
                  CLS_B: begin
                     branch   = 1'b1;
                     pc_write = 1'b1;
                     pc_src   = 1'b1;
                     retire   = 1'b1;
                  end
                  CLS_ILLEGAL: illegal = 1'b1;
                  default: ;
               endcase
            end
            S_MEM: begin
               mem_fault = w_timeout;
               if (cls_q == CLS_LDUR) begin
                  mem_read = !w_timeout;
                  ior_d    = 1'b1;
               end else if (cls_q == CLS_STUR) begin
                  mem_write = !w_timeout;
                  ior_d     = 1'b1;
                  reg2loc   = 1'b1;
                  retire    = mem_ready;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls_q == CLS_LDUR);
               retire     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_legv8_mc_control.sv
`default_nettype none
// ============================================================================
//  tb_legv8_mc_control : directed self-checking bench for legv8_mc_control
//  Revision 1.0
// ============================================================================
module tb_legv8_mc_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;
   logic        reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0]  alu_op;
   logic        ior_d, ir_write, pc_write, pc_src, retire, illegal, mem_fault;
   logic [2:0]  state;
   logic [18:0] all_outs;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_B    = 11'b00010100000;

   legv8_mc_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .reg2loc    (reg2loc),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .alu_op     (alu_op),
      .ior_d      (ior_d),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .retire     (retire),
      .illegal    (illegal),
      .mem_fault  (mem_fault),
      .state      (state)
   );

   assign all_outs = {state, reg2loc, alu_src, mem_to_reg, reg_write, mem_read,
                      mem_write, branch, alu_op, ior_d, ir_write, pc_write,
                      pc_src, retire, illegal, mem_fault};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Walk IF and ID with immediate fetch, leaving the FSM settled in EX.
   task automatic fetch_decode(input logic [10:0] op);
      opcode    = op;
      mem_ready = 1'b1;
      #1;
      check("if_state", 32'(state), 32'd0);
      check("if_irw", 32'({ir_write, pc_write, pc_src, mem_read, ior_d}), 32'b11010);
      step();
      #1;
      check("id_state", 32'(state), 32'd1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      opcode    = OP_ADD;
      zero      = 1'b0;
      mem_ready = 1'b1;
      repeat (2) step();
      check("reset_outs", 32'(all_outs), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_state", 32'(state), 32'd0);
      check("rel_mem_read", 32'(mem_read), 32'd1);

      // RTYPE ADD: IF, ID, EX, WB
      fetch_decode(OP_ADD);
      check("rt_ex", 32'({state, alu_op, alu_src, reg_write}), {27'd0, 3'd2, 2'b10, 1'b0, 1'b0});
      step();
      check("rt_wb", 32'({state, reg_write, mem_to_reg, retire}), {26'd0, 3'd4, 1'b1, 1'b0, 1'b1});
      step();
      check("rt_done", 32'(state), 32'd0);

      // LDUR with three wait cycles in MEM
      fetch_decode(OP_LDUR);
      mem_ready = 1'b0;
      #1;
      check("ld_ex", 32'({state, alu_op, alu_src, reg2loc}), {27'd0, 3'd2, 2'b00, 1'b1, 1'b0});
      step();
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         check("ld_mem", 32'({state, ior_d, mem_read, reg_write, mem_fault}), {25'd0, 3'd3, 4'b1100});
         step();
      end
      check("ld_wb", 32'({state, reg_write, mem_to_reg, retire}), {26'd0, 3'd4, 3'b111});
      step();

      // STUR
      fetch_decode(OP_STUR);
      check("st_ex", 32'({state, reg2loc, alu_src}), {27'd0, 3'd2, 2'b11});
      step();
      check("st_mem", 32'({state, mem_write, mem_read, ior_d, reg2loc, retire}), {24'd0, 3'd3, 5'b10111});
      step();
      check("st_done", 32'(state), 32'd0);

      // CBZ taken then not taken
      fetch_decode(OP_CBZ);
      zero = 1'b1;
      #1;
      check("cbz_t", 32'({alu_op, branch, pc_write, pc_src, retire, reg2loc}), {25'd0, 2'b01, 5'b11111});
      step();
      check("cbz_t_if", 32'(state), 32'd0);
      fetch_decode(OP_CBZ);
      zero = 1'b0;
      #1;
      check("cbz_nt", 32'({branch, pc_write, retire}), {29'd0, 3'b101});
      step();
      check("cbz_nt_if", 32'(state), 32'd0);

      // Illegal opcode
      fetch_decode(11'd0);
      check("ill_ex", 32'({illegal, reg_write, mem_write, pc_write, ir_write, retire}), {26'd0, 6'b100000});
      step();
      check("ill_if", 32'(state), 32'd0);

      // Unconditional B
      fetch_decode(OP_B);
`ifdef LEGV8_B_EN
      check("b_ex", 32'({pc_write, pc_src, branch, retire, illegal}), {27'd0, 5'b11110});
`else
      check("b_ex", 32'({pc_write, pc_src, branch, retire, illegal}), {27'd0, 5'b00001});
`endif
      step();

      // IF timeout: fault on the 16th waiting cycle
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         check("if_wait", 32'({state, mem_fault, ir_write, mem_read}), {29'd0, 3'b001});
         step();
      end
      check("if_fault", 32'({state, mem_fault, ir_write, pc_write, mem_read}), {28'd0, 4'b1000});
      step();
      check("if_after", 32'({state, mem_fault, mem_read}), {30'd0, 2'b01});

      // mem_ready on the final count is a success
      for (int i = 0; i < 15; i++) step();
      mem_ready = 1'b1;
      opcode    = OP_LDUR;
      #1;
      check("if_edge_ok", 32'({mem_fault, ir_write}), 32'b01);
      step();
      check("edge_id", 32'(state), 32'd1);
      step();
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 15; i++) step();
      check("mem_fault", 32'({state, mem_fault, mem_read, reg_write}), {26'd0, 3'd3, 3'b100});
      step();
      check("mem_after", 32'({state, reg_write, retire}), 32'd0);

      // Asynchronous reset in the middle of a MEM wait
      fetch_decode(OP_LDUR);
      mem_ready = 1'b0;
      step();
      step();
      check("pre_rst", 32'(state), 32'd3);
      rst_n = 1'b0;
      #1;
      check("mid_rst", 32'(all_outs), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst", 32'({state, mem_read, ior_d}), {27'd0, 3'd0, 2'b10});

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
